// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit that owns HI/LO.
package muldiv_pkg;

   localparam int unsigned MD_WIDTH = 32;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10
   } md_state_t;

   function automatic logic op_is_signed(md_op_t op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage view of the mul/div unit: pipeline (master) drives requests, unit (slave) answers.
interface muldiv_if import muldiv_pkg::*; #(
   parameter int unsigned WIDTH = MD_WIDTH
) ();

   logic             startE;
   logic [1:0]       opE;
   logic [WIDTH-1:0] srcaE;
   logic [WIDTH-1:0] srcbE;
   logic             mthiE;
   logic             mtloE;
   logic             readhiloE;
   logic             busy;
   logic             stallmdE;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output startE, opE, srcaE, srcbE, mthiE, mtloE, readhiloE,
      input  busy, stallmdE, done, hi, lo
   );

   modport slave (
      input  startE, opE, srcaE, srcbE, mthiE, mtloE, readhiloE,
      output busy, stallmdE, done, hi, lo
   );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on {acc, shreg}: shift-add for multiply, restoring subtract for divide.
module muldiv_step import muldiv_pkg::*; #(
   parameter int unsigned WIDTH = MD_WIDTH
) (
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] shreg_i,
   input  logic [WIDTH-1:0] oper_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] shreg_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] rem;
   logic [WIDTH:0] diff;

   always_comb begin
      sum  = {1'b0, acc_i} + {1'b0, oper_i};
      rem  = {acc_i, shreg_i[WIDTH-1]};
      diff = rem - {1'b0, oper_i};
      if (is_div_i) begin
         // Borrow out of the trial subtract means the partial remainder is below the divisor.
         if (!diff[WIDTH]) begin
            acc_o   = diff[WIDTH-1:0];
            shreg_o = {shreg_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_o   = rem[WIDTH-1:0];
            shreg_o = {shreg_i[WIDTH-2:0], 1'b0};
         end
      end else if (shreg_i[0]) begin
         acc_o   = sum[WIDTH:1];
         shreg_o = {sum[0], shreg_i[WIDTH-1:1]};
      end else begin
         acc_o   = {1'b0, acc_i[WIDTH-1:1]};
         shreg_o = {acc_i[0], shreg_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer holding HI/LO; stalls dependent execute-stage ops.
module muldiv_seq import muldiv_pkg::*; #(
   parameter int unsigned WIDTH = MD_WIDTH
) (
   input logic     clk,
   input logic     reset,
   muldiv_if.slave md
);

   localparam int unsigned CntW = $clog2(WIDTH);

   md_state_t          state_q;
   logic [CntW-1:0]    cnt_q;
   logic [WIDTH-1:0]   acc_q, shreg_q, oper_q, srca_q, hi_q, lo_q;
   logic [WIDTH-1:0]   acc_d, shreg_d;
   logic               is_div_q, neg_q, rneg_q, divzero_q, done_q;
   md_op_t             op;
   logic               a_neg, b_neg, busy;
   logic [WIDTH-1:0]   a_mag, b_mag, fix_hi, fix_lo;
   logic [2*WIDTH-1:0] prod_fix;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div_i (is_div_q),
      .acc_i    (acc_q),
      .shreg_i  (shreg_q),
      .oper_i   (oper_q),
      .acc_o    (acc_d),
      .shreg_o  (shreg_d)
   );

   always_comb begin
      op       = md_op_t'(md.opE);
      a_neg    = op_is_signed(op) & md.srcaE[WIDTH-1];
      b_neg    = op_is_signed(op) & md.srcbE[WIDTH-1];
      a_mag    = a_neg ? -md.srcaE : md.srcaE;
      b_mag    = b_neg ? -md.srcbE : md.srcbE;
      prod_fix = neg_q ? -{acc_q, shreg_q} : {acc_q, shreg_q};
      fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo   = prod_fix[WIDTH-1:0];
      if (is_div_q) begin
         if (divzero_q) begin
            fix_hi = srca_q;
            fix_lo = '1;
         end else begin
            fix_hi = rneg_q ? -acc_q : acc_q;
            fix_lo = neg_q ? -shreg_q : shreg_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (md.startE) begin
                  // Magnitudes go in; the signs are reapplied in FIX.
                  is_div_q  <= op[1];
                  neg_q     <= a_neg ^ b_neg;
                  rneg_q    <= a_neg;
                  divzero_q <= (md.srcbE == '0);
                  srca_q    <= md.srcaE;
                  acc_q     <= '0;
                  shreg_q   <= op[1] ? a_mag : b_mag;
                  oper_q    <= op[1] ? b_mag : a_mag;
                  cnt_q     <= CntW'(WIDTH - 1);
                  state_q   <= RUN;
               end else begin
                  if (md.mthiE) hi_q <= md.srcaE;
                  if (md.mtloE) lo_q <= md.srcaE;
               end
            end
            RUN: begin
               acc_q   <= acc_d;
               shreg_q <= shreg_d;
               cnt_q   <= cnt_q - CntW'(1);
               if (cnt_q == '0) state_q <= FIX;
            end
            FIX: begin
               hi_q    <= fix_hi;
               lo_q    <= fix_lo;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy        = (state_q != IDLE);
   assign md.busy     = busy;
   assign md.stallmdE = busy & (md.startE | md.readhiloE | md.mthiE | md.mtloE);
   assign md.done     = done_q;
   assign md.hi       = hi_q;
   assign md.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized scoreboard bench for muldiv_seq against a 64-bit arithmetic reference model.
module tb_muldiv_seq;
   import muldiv_pkg::*;

   localparam int unsigned W = MD_WIDTH;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } dir_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] exp_q[$];
   logic [63:0] mon_exp;
   logic [31:0] m_hi, m_lo;
   int          checks = 0;
   int          errors = 0;
   dir_t        dirs[5];

   always #5 clk = ~clk;

   muldiv_if #(.WIDTH(W)) md_if ();

   muldiv_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (md_if)
   );

   function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint          sa, sb, sp, sq, sr;
      longint unsigned up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: begin sp = sa * sb; return sp; end
         2'b01: begin up = {32'b0, a} * {32'b0, b}; return up; end
         2'b10: begin
            if (b == 32'h0) return {a, 32'hFFFFFFFF};
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
         end
         default: begin
            if (b == 32'h0) return {a, 32'hFFFFFFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      md_if.startE    = 1'b0;
      md_if.mthiE     = 1'b0;
      md_if.mtloE     = 1'b0;
      md_if.readhiloE = 1'b0;
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r;
      md_if.startE = 1'b1;
      md_if.opE    = op;
      md_if.srcaE  = a;
      md_if.srcbE  = b;
      r = ref_model(op, a, b);
      exp_q.push_back(r);
      {m_hi, m_lo} = r;
   endtask

   // Counts busy cycles from the current cycle until the unit goes idle (bounded).
   task automatic count_busy(output int n);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         if (md_if.busy !== 1'b1) break;
         n++;
         tick();
      end
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int n;
      issue(op, a, b);
      tick();
      clear_inputs();
      count_busy(n);
      chk("latency", 64'(n), 64'(W + 1));
   endtask

   // Scoreboard monitor: every completion pops one expected {hi, lo}.
   always @(negedge clk) begin
      if (md_if.done === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected got hi=%h lo=%h expected no completion",
                     md_if.hi, md_if.lo);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({md_if.hi, md_if.lo} !== mon_exp) begin
               errors++;
               $display("FAIL result got %h expected %h at %0t", {md_if.hi, md_if.lo},
                        mon_exp, $time);
            end
         end
      end
   end

   initial begin
      int n;
      logic [63:0] old;
      logic [31:0] a, b, d;
      logic [1:0]  op;
      logic        mh, ml;

      dirs[0] = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
      dirs[1] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      dirs[2] = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
      dirs[3] = '{2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
      dirs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};

      reset = 1'b1;
      clear_inputs();
      md_if.opE   = 2'b00;
      md_if.srcaE = '0;
      md_if.srcbE = '0;
      m_hi = '0;
      m_lo = '0;
      repeat (3) tick();
      reset = 1'b0;
      chk("reset_busy", 64'(md_if.busy), 64'h0);
      chk("reset_done", 64'(md_if.done), 64'h0);
      chk("reset_stall", 64'(md_if.stallmdE), 64'h0);
      chk("reset_hilo", {md_if.hi, md_if.lo}, 64'h0);

      // MULTU all-ones squared with cycle-exact busy/done timing.
      issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      for (int c = 1; c <= W + 2; c++) begin
         tick();
         if (c == 1) clear_inputs();
         chk("busy_timing", 64'(md_if.busy), 64'(c <= W + 1));
         chk("done_timing", 64'(md_if.done), 64'(c == W + 2));
      end
      chk("multu_max", {md_if.hi, md_if.lo}, 64'hFFFFFFFE_00000001);

      foreach (dirs[i]) begin
         run_op(dirs[i].op, dirs[i].a, dirs[i].b);
         chk("directed", {md_if.hi, md_if.lo}, {dirs[i].hi, dirs[i].lo});
      end

      // Dependent MFLO and a second mul/div held behind an in-flight MULTU.
      issue(MD_MULTU, 32'd6, 32'd7);
      for (int c = 1; c <= W + 2; c++) begin
         tick();
         if (c == 1) clear_inputs();
         if (c == 3) issue(MD_DIVU, 32'd100, 32'd7);
         if (c == 5) md_if.readhiloE = 1'b1;
         #1;
         chk("stall", 64'(md_if.stallmdE), 64'((c >= 3) && (c <= W + 1)));
      end
      chk("held_mflo", {md_if.hi, md_if.lo}, 64'd42);
      chk("held_done", 64'(md_if.done), 64'h1);
      tick();
      clear_inputs();
      count_busy(n);
      chk("held_start_latency", 64'(n), 64'(W + 1));

      // startE wins over simultaneous MTHI/MTLO.
      old = {m_hi, m_lo};
      md_if.mthiE = 1'b1;
      md_if.mtloE = 1'b1;
      issue(MD_MULTU, 32'd3, 32'd5);
      tick();
      chk("start_priority", {md_if.hi, md_if.lo}, old);
      clear_inputs();
      count_busy(n);
      chk("latency", 64'(n), 64'(W + 1));

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            mh = 1'($urandom_range(0, 1));
            ml = mh ? 1'($urandom_range(0, 1)) : 1'b1;
            d  = $urandom;
            md_if.mthiE = mh;
            md_if.mtloE = ml;
            md_if.srcaE = d;
            if (mh) m_hi = d;
            if (ml) m_lo = d;
            tick();
            clear_inputs();
            chk("mthi_mtlo", {md_if.hi, md_if.lo}, {m_hi, m_lo});
         end else begin
            op = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            run_op(op, a, b);
         end
      end

      // Reset in cycle 10 of a DIV aborts it.
      issue(MD_DIV, 32'hFFFFFF9C, 32'd3);
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 1) clear_inputs();
      end
      reset = 1'b1;
      exp_q.delete();
      tick();
      reset = 1'b0;
      m_hi = '0;
      m_lo = '0;
      chk("abort_busy", 64'(md_if.busy), 64'h0);
      chk("abort_hilo", {md_if.hi, md_if.lo}, 64'h0);
      chk("abort_done", 64'(md_if.done), 64'h0);
      repeat (50) tick();
      md_if.mthiE = 1'b1;
      md_if.srcaE = 32'h1234;
      tick();
      clear_inputs();
      chk("mthi_after_abort", {md_if.hi, md_if.lo}, {32'h1234, 32'h0});
      repeat (3) tick();

      chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative multiply/divide sequencer for the pipelined MIPS core. It owns the architectural HI/LO registers and runs MULT/MULTU/DIV/DIVU in the execute stage with a radix-2 shift-add or restoring-divide loop. While an operation is in flight it raises a stall when a dependent instruction (MFHI/MFLO, MTHI/MTLO or another mul/div) reaches execute. The stall is ORed into the hazard unit's stall/flush network.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; the iteration count equals WIDTH.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
startE  input  1  mul/div instruction in execute this cycle
opE  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
srcaE  input  WIDTH  rs operand after forwarding (multiplicand/dividend; MTHI/MTLO data)
srcbE  input  WIDTH  rt operand after forwarding (multiplier/divisor)
mthiE  input  1  MTHI in execute
mtloE  input  1  MTLO in execute
readhiloE  input  1  MFHI/MFLO in execute
busy  output  1  operation in flight
stallmdE  output  1  request to hold F/D/E and bubble into M
done  output  1  one-cycle pulse when HI/LO are updated by a mul/div
hi  output  WIDTH  HI register (registered)
lo  output  WIDTH  LO register (registered)

Behaviour:
- Reset, sampled synchronously, forces state IDLE and sets hi=0, lo=0, busy=0, done=0. The shift/accumulator registers are don't-care after reset.
- Reset mid-operation aborts the operation: no done pulse and no HI/LO update.
- FSM states are IDLE, RUN, FIX.
- IDLE -> RUN: on startE=1.
  - Operands are latched.
  - Signed ops (MULT, DIV) store the absolute values plus result-sign flags.
  - Iteration counter is loaded with WIDTH-1.
- RUN: one iteration per cycle for exactly WIDTH cycles. RUN -> FIX when the counter reaches 0.
- FIX: one cycle.
  - Apply the two's-complement sign correction.
  - Write HI/LO at the end of FIX, then go to IDLE.
- Timing, with start accepted in cycle 0:
  - busy=1 in cycles 1..WIDTH+1.
  - New hi/lo are visible, and done=1, in cycle WIDTH+2.
  - done is also 0 in cycles that carry no completion.
- stallmdE = busy & (startE | readhiloE | mthiE | mtloE). The stall is combinational; no stall is raised in IDLE.
- The cycle in which hi/lo update (WIDTH+2) is IDLE. A held MFHI/MFLO reads the new values directly from the hi/lo outputs, with no bypass.
- startE while busy is ignored internally. The stall holds the instruction so it is re-presented once the unit is idle.
- MTHI/MTLO when not busy:
  - hi <= srcaE (mthiE) and/or lo <= srcaE (mtloE) at the clock edge.
  - Both may be asserted in the same cycle.
  - startE has priority over mthiE/mtloE if asserted together.
- Multiply:
  - {hi,lo} = full 2*WIDTH-bit product.
  - MULT negates the product in FIX if exactly one operand was negative.
- Divide:
  - lo = quotient, hi = remainder.
  - Quotient is negated if the operand signs differ; remainder takes the sign of the dividend (truncation toward zero).
- Divide by zero: lo=all ones and hi=srcaE as originally latched, for both DIV and DIVU. The sign fix is skipped and the latency is unchanged.
- -2^(WIDTH-1) / -1 gives lo=0x80000000, hi=0, with no trap.
- Magnitude of -2^(WIDTH-1) is held as an unsigned WIDTH-bit value; no overflow results.

Decomposition:
- Package muldiv_pkg holds:
  - md_op_t enum: MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11.
  - md_state_t enum: IDLE, RUN, FIX.
  - Constant MD_WIDTH=32.
- One combinational sub-module, muldiv_step, performs a single shift-add or restoring-subtract iteration on {acc, shreg}. The FSM, counter, sign fix and HI/LO registers stay in muldiv_seq.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy in cycles 1..33; hi=0xFFFFFFFE, lo=0x00000001 in cycle 34 with done=1.
- MULT 0xFFFFFFFD (-3) x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV 0xFFFFFFF9 (-7) / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
- DIVU 5/0 and DIV 0x80000000/0xFFFFFFFF -> (lo=0xFFFFFFFF, hi=5) and (lo=0x80000000, hi=0), each after 33 busy cycles.
- readhiloE held from cycle 5 of a MULTU 6x7 -> stallmdE=1 in cycles 5..33, 0 in cycle 34 with lo=42 readable. A second startE in cycle 3 stalls and is not started until cycle 34.
- reset in cycle 10 of a DIV -> cycle 11: busy=0, hi=lo=0, no done pulse ever. Subsequent mthiE with srcaE=0x1234 -> hi=0x1234 next cycle.
